// File: rtl/dot11_tx_sched_pkg.sv
// Shared types and helpers for the dot11_tx frame scheduler.
// Optional watchdog is enabled by DOT11_TX_SCHED_WATCHDOG_EN in the top.
package dot11_tx_sched_pkg;

  localparam int unsigned SCRAM_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } sched_state_e;

  localparam logic [SCRAM_W-1:0] LFSR_INIT        = 7'h7F;
  localparam logic [SCRAM_W-1:0] PILOT_SCRAM_INIT = 7'h7F;

  // x^7 + x^4 + 1 Fibonacci step; maximal length, so a non-zero seed never reaches 0
  function automatic logic [SCRAM_W-1:0] lfsr_next(input logic [SCRAM_W-1:0] s);
    return {s[5:0], s[6] ^ s[3]};
  endfunction

endpackage

// File: rtl/dot11_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// Shared between the TX and RX schedulers.
module rr_arbiter #(
  parameter int unsigned NUM_Q = 4
) (
  input  logic [NUM_Q-1:0]         req,
  input  logic [$clog2(NUM_Q)-1:0] ptr,
  output logic [NUM_Q-1:0]         gnt,
  output logic [$clog2(NUM_Q)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_Q);

  logic              found;
  int unsigned       k;
  logic [IDX_W-1:0]  k_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    k_idx   = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      k     = (32'(ptr) + i) % NUM_Q;
      k_idx = IDX_W'(k);
      if (!found && req[k_idx]) begin
        found      = 1'b1;
        gnt[k_idx] = 1'b1;
        gnt_idx    = k_idx;
      end
    end
  end

endmodule

// File: rtl/dot11_tx_sched.sv
// Frame scheduler in front of dot11_tx: RR queue grant, BRAM relocation, seed, IFS gap.
// Define DOT11_TX_SCHED_WATCHDOG_EN to abort frames that never report phy_tx_done.
module dot11_tx_sched
  import dot11_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_Q           = 4,
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned GAP_W           = 16,
  parameter int unsigned WATCHDOG_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic [NUM_Q-1:0]          q_req,
  input  logic [NUM_Q*ADDR_W-1:0]   q_base_addr,
  input  logic [GAP_W-1:0]          gap_cycles,
  output logic [NUM_Q-1:0]          q_grant,
  output logic [NUM_Q-1:0]          q_done,
  output logic [NUM_Q-1:0]          q_err,
  output logic                      busy,
  output logic [$clog2(NUM_Q)-1:0]  cur_q,
  output logic                      phy_tx_start,
  input  logic                      phy_tx_started,
  input  logic                      phy_tx_done,
  input  logic [ADDR_W-1:0]         phy_bram_addr,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [SCRAM_W-1:0]        init_data_scram_state,
  output logic [SCRAM_W-1:0]        init_pilot_scram_state
);

  localparam int unsigned IDX_W = $clog2(NUM_Q);

  sched_state_e       state;
  logic [ADDR_W-1:0]  base_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_Q-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [ADDR_W-1:0]  base_arr [NUM_Q];
  logic               launch;
  logic               wd_hit;

  for (genvar i = 0; i < NUM_Q; i++) begin : g_base
    assign base_arr[i] = q_base_addr[i*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(
    .NUM_Q (NUM_Q)
  ) u_arb (
    .req     (q_req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign launch                 = (state == ST_IDLE) && enable && (|q_req);
  // Relocation stays combinational so the dot11_tx BRAM read path sees no extra cycle
  assign bram_addr              = base_q + phy_bram_addr;
  assign init_pilot_scram_state = PILOT_SCRAM_INIT;

`ifdef DOT11_TX_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

  // Cycles spent in START/WAIT_DONE since the last grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (launch) begin
      wd_cnt <= '0;
    end else if (state == ST_START || state == ST_WAIT_DONE) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                 <= ST_IDLE;
      base_q                <= '0;
      rr_ptr                <= '0;
      gap_cnt               <= '0;
      cur_q                 <= '0;
      q_grant               <= '0;
      q_done                <= '0;
      q_err                 <= '0;
      busy                  <= 1'b0;
      phy_tx_start          <= 1'b0;
      init_data_scram_state <= LFSR_INIT;
    end else begin
      q_grant <= '0;
      q_done  <= '0;
      q_err   <= '0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            base_q       <= base_arr[arb_idx];
            cur_q        <= arb_idx;
            q_grant      <= arb_gnt;
            rr_ptr       <= (arb_idx == IDX_W'(NUM_Q - 1)) ? '0 : arb_idx + IDX_W'(1);
            phy_tx_start <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_START;
          end
        end
        // done outranks started and the watchdog, even while still in START
        ST_START, ST_WAIT_DONE: begin
          if (phy_tx_done) begin
            q_done                <= NUM_Q'(1) << cur_q;
            init_data_scram_state <= lfsr_next(init_data_scram_state);
            gap_cnt               <= gap_cycles;
            phy_tx_start          <= 1'b0;
            state                 <= ST_GAP;
          end else if (wd_hit) begin
            q_err        <= NUM_Q'(1) << cur_q;
            gap_cnt      <= gap_cycles;
            phy_tx_start <= 1'b0;
            state        <= ST_GAP;
          end else if (state == ST_START && phy_tx_started) begin
            phy_tx_start <= 1'b0;
            state        <= ST_WAIT_DONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          busy         <= 1'b0;
          phy_tx_start <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot11_tx_sched.sv
// Directed bench for dot11_tx_sched: RR order, relocation, seed chain, gap, enable, reset.
// With DOT11_TX_SCHED_WATCHDOG_EN defined the DUT is built with a 100-cycle watchdog.
module tb_dot11_tx_sched;

  localparam int unsigned NUM_Q  = 4;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned GAP_W  = 16;
`ifdef DOT11_TX_SCHED_WATCHDOG_EN
  localparam int unsigned WD_CYC = 100;
`else
  localparam int unsigned WD_CYC = 65535;
`endif

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     enable;
  logic [NUM_Q-1:0]         q_req;
  logic [NUM_Q*ADDR_W-1:0]  q_base_addr;
  logic [GAP_W-1:0]         gap_cycles;
  logic [NUM_Q-1:0]         q_grant;
  logic [NUM_Q-1:0]         q_done;
  logic [NUM_Q-1:0]         q_err;
  logic                     busy;
  logic [1:0]               cur_q;
  logic                     phy_tx_start;
  logic                     phy_tx_started;
  logic                     phy_tx_done;
  logic [ADDR_W-1:0]        phy_bram_addr;
  logic [ADDR_W-1:0]        bram_addr;
  logic [6:0]               init_data_scram_state;
  logic [6:0]               init_pilot_scram_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot11_tx_sched #(
    .NUM_Q           (NUM_Q),
    .ADDR_W          (ADDR_W),
    .GAP_W           (GAP_W),
    .WATCHDOG_CYCLES (WD_CYC)
  ) u_dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .enable                 (enable),
    .q_req                  (q_req),
    .q_base_addr            (q_base_addr),
    .gap_cycles             (gap_cycles),
    .q_grant                (q_grant),
    .q_done                 (q_done),
    .q_err                  (q_err),
    .busy                   (busy),
    .cur_q                  (cur_q),
    .phy_tx_start           (phy_tx_start),
    .phy_tx_started         (phy_tx_started),
    .phy_tx_done            (phy_tx_done),
    .phy_bram_addr          (phy_bram_addr),
    .bram_addr              (bram_addr),
    .init_data_scram_state  (init_data_scram_state),
    .init_pilot_scram_state (init_pilot_scram_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full frame: wait for grant, handshake started then done; returns one negedge after q_done
  task automatic do_frame(input logic [3:0] exp_gnt, input logic [1:0] exp_q,
                          input logic [6:0] exp_seed, input logic [9:0] addr,
                          input logic [9:0] exp_addr, input logic dis_mid);
    int n;
    n = 0;
    while (q_grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_in_time", 32'(n < 20), 32'd1);
    chk("q_grant", 32'(q_grant), 32'(exp_gnt));
    chk("cur_q", 32'(cur_q), 32'(exp_q));
    chk("busy_frame", 32'(busy), 32'd1);
    chk("start_high", 32'(phy_tx_start), 32'd1);
    chk("seed", 32'(init_data_scram_state), 32'(exp_seed));
    chk("pilot_seed", 32'(init_pilot_scram_state), 32'h7F);
    if (dis_mid) enable = 1'b0;
    phy_bram_addr = addr;
    #1;
    chk("bram_addr", 32'(bram_addr), 32'(exp_addr));
    @(negedge clk);
    chk("grant_pulse_1cyc", 32'(q_grant), 32'd0);
    chk("start_held", 32'(phy_tx_start), 32'd1);
    phy_tx_started = 1'b1;
    @(negedge clk);
    chk("start_dropped", 32'(phy_tx_start), 32'd0);
    phy_tx_started = 1'b0;
    phy_tx_done    = 1'b1;
    @(negedge clk);
    phy_tx_done = 1'b0;
    chk("q_done", 32'(q_done), 32'(exp_gnt));
    chk("q_err_quiet", 32'(q_err), 32'd0);
    @(negedge clk);
    chk("done_pulse_1cyc", 32'(q_done), 32'd0);
  endtask

  initial begin
    logic seen;
    int   n;
    rstn           = 1'b0;
    enable         = 1'b0;
    q_req          = '0;
    q_base_addr    = {10'h3F0, 10'h100, 10'h040, 10'h000};
    gap_cycles     = 16'd3;
    phy_tx_started = 1'b0;
    phy_tx_done    = 1'b0;
    phy_bram_addr  = '0;

    @(negedge clk);
    chk("rst_grant", 32'(q_grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(phy_tx_start), 32'd0);
    chk("rst_cur_q", 32'(cur_q), 32'd0);
    chk("rst_seed", 32'(init_data_scram_state), 32'h7F);
    chk("rst_pilot", 32'(init_pilot_scram_state), 32'h7F);

    // All queues held: q0..q3 then back to q0; seed walks the LFSR chain
    rstn   = 1'b1;
    enable = 1'b1;
    q_req  = 4'b1111;
    do_frame(4'b0001, 2'd0, 7'h7F, 10'h005, 10'h005, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("gap_end_idle", 32'(busy), 32'd0);
    chk("gap_no_grant", 32'(q_grant), 32'd0);
    do_frame(4'b0010, 2'd1, 7'h7E, 10'h005, 10'h045, 1'b0);
    do_frame(4'b0100, 2'd2, 7'h7C, 10'h005, 10'h105, 1'b0);
    do_frame(4'b1000, 2'd3, 7'h78, 10'h020, 10'h010, 1'b0);
    do_frame(4'b0001, 2'd0, 7'h70, 10'h3FF, 10'h3FF, 1'b1);

    // enable dropped mid-frame: that frame finished, nothing new granted
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (q_grant != '0) seen = 1'b1;
    end
    chk("disabled_no_grant", 32'(seen), 32'd0);
    chk("disabled_idle", 32'(busy), 32'd0);

    // gap_cycles = 0: idle one cycle after done
    gap_cycles = 16'd0;
    enable     = 1'b1;
    q_req      = 4'b0010;
    do_frame(4'b0010, 2'd1, 7'h61, 10'h00A, 10'h04A, 1'b0);
    chk("gap0_idle", 32'(busy), 32'd0);
    q_req = '0;
    @(negedge clk);
    chk("gap0_no_regrant", 32'(q_grant), 32'd0);
    gap_cycles = 16'd3;

    // Reset asserted while phy_tx_start is high
    q_req = 4'b0100;
    @(negedge clk);
    chk("pre_rst_grant", 32'(q_grant), 32'b0100);
    chk("pre_rst_seed", 32'(init_data_scram_state), 32'h43);
    q_req = '0;
    rstn  = 1'b0;
    #1;
    chk("midrst_start", 32'(phy_tx_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cur_q", 32'(cur_q), 32'd0);
    chk("midrst_seed", 32'(init_data_scram_state), 32'h7F);
    @(negedge clk);
    rstn  = 1'b1;
    q_req = 4'b1100;
    @(negedge clk);
    chk("ptr_reset_grant", 32'(q_grant), 32'b0100);
    q_req = '0;

`ifdef DOT11_TX_SCHED_WATCHDOG_EN
    seen = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (q_err != '0 || q_done != '0) seen = 1'b1;
    end
    chk("wd_early", 32'(seen), 32'd0);
    @(negedge clk);
    chk("wd_q_err", 32'(q_err), 32'b0100);
    chk("wd_no_done", 32'(q_done), 32'd0);
    chk("wd_start_low", 32'(phy_tx_start), 32'd0);
    chk("wd_seed_kept", 32'(init_data_scram_state), 32'h7F);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wd_back_idle", 32'(busy), 32'd0);
`else
    n = 0;
    seen = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      if (q_err != '0 || q_done != '0) seen = 1'b1;
      n++;
    end
    chk("hang_no_err", 32'(seen), 32'd0);
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_start", 32'(phy_tx_start), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
